// File: rtl/decode_stage.sv
// Handshaked decode stage for the accumulator CPU: opcode decode, flag-based branch
// resolution and per-accumulator pending-flag interlock. Optional macro: DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 6,
    parameter int NUM_ACC = 2,
    parameter int ADDR_W  = 10,
    parameter int IMM_W   = 8,
    parameter int BR_W    = 6,
    parameter int PEND_W  = 2,
    localparam int ACC_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instr,
    input  logic [3*NUM_ACC-1:0]   flags,
    input  logic                   flag_wb_valid,
    input  logic [ACC_W-1:0]       flag_wb_idx,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NUM_ACC-1:0]   acc_sel,
    output logic [ACC_W-1:0]       acc_idx,
    output logic [2:0]             alu_op,
    output logic                   mem_wr,
    output logic                   jmp_en,
    output logic                   branch_en,
    output logic                   illegal,
    output logic [IMM_W-1:0]       imm,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ADDR_W-1:0]      jmp_addr,
    output logic [BR_W-1:0]        branch_off
);

    logic [OP_W-1:0]       op;
    logic [1:0]            cls;
    logic [2:0]            sub;
    logic [ACC_W-1:0]      acc;
    logic                  acc_ok;
    logic [2:0]            acc_flags;
    logic [PEND_W-1:0]     pend [NUM_ACC];
    logic [PEND_W-1:0]     pend_cur;

    logic [2*NUM_ACC-1:0]  d_acc_sel;
    logic [ACC_W-1:0]      d_acc_idx;
    logic [2:0]            d_alu_op;
    logic                  d_mem_wr;
    logic                  d_jmp_en;
    logic                  d_branch_en;
    logic                  d_illegal;
    logic                  is_alu;
    logic                  is_cond;
    logic                  bad;
    logic                  stall;
    logic                  run;
    logic                  accept;

    assign op       = instr[INSTR_W-1 -: OP_W];
    assign cls      = op[OP_W-1 -: 2];
    assign sub      = op[OP_W-3 -: 3];
    assign acc      = op[ACC_W-1:0];
    assign acc_ok   = (32'(acc) < NUM_ACC);
    assign pend_cur = acc_ok ? pend[acc] : '0;

    always_comb begin
        acc_flags = 3'b000;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (32'(acc) == i) acc_flags = flags[3*i +: 3];
        end
    end

    always_comb begin
        d_acc_sel   = '0;
        d_acc_idx   = acc;
        d_alu_op    = 3'd0;
        d_mem_wr    = 1'b0;
        d_jmp_en    = 1'b0;
        d_branch_en = 1'b0;
        is_alu      = 1'b0;
        is_cond     = 1'b0;
        bad         = 1'b0;
        case (cls)
            2'b00: begin
                case (sub)
                    3'b000:  d_acc_sel[2*32'(acc) +: 2] = 2'b11;
                    3'b001:  d_acc_sel[2*32'(acc) +: 2] = 2'b01;
                    3'b010:  d_mem_wr = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            2'b01: begin
                d_acc_sel[2*32'(acc) +: 2] = 2'b10;
                d_alu_op = sub;
                is_alu   = 1'b1;
            end
            2'b10: begin
                // flags per accumulator are {z,c,n}
                is_cond = (sub != 3'b000) && (sub != 3'b111);
                case (sub)
                    3'b000:  d_jmp_en    = 1'b1;
                    3'b001:  d_branch_en = acc_flags[2];
                    3'b010:  d_branch_en = !acc_flags[2];
                    3'b011:  d_branch_en = acc_flags[1];
                    3'b100:  d_branch_en = !acc_flags[1];
                    3'b101:  d_branch_en = acc_flags[0];
                    3'b110:  d_branch_en = !acc_flags[0];
                    default: bad = 1'b1;
                endcase
            end
            default: begin
                d_acc_idx = '0;
                if (op[OP_W-3:0] != '0) bad = 1'b1;
            end
        endcase
        if (!acc_ok && cls != 2'b11) bad = 1'b1;
        if (bad) begin
            d_acc_sel   = '0;
            d_acc_idx   = '0;
            d_alu_op    = 3'd0;
            d_mem_wr    = 1'b0;
            d_jmp_en    = 1'b0;
            d_branch_en = 1'b0;
            is_alu      = 1'b0;
            is_cond     = 1'b0;
        end
    end

    assign stall    = (is_cond && pend_cur != '0) || (is_alu && pend_cur == '1);
    assign in_ready = (!out_valid || out_ready) && !stall && !flush && run;
    assign accept   = in_valid && in_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && bad) state_d = TRAP;
            TRAP:    if (flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign run       = (state_q == RUN);
    assign d_illegal = bad;
`else
    assign run       = 1'b1;
    assign d_illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            acc_sel    <= '0;
            acc_idx    <= '0;
            alu_op     <= 3'd0;
            mem_wr     <= 1'b0;
            jmp_en     <= 1'b0;
            branch_en  <= 1'b0;
            illegal    <= 1'b0;
            imm        <= '0;
            mem_addr   <= '0;
            jmp_addr   <= '0;
            branch_off <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            acc_sel    <= d_acc_sel;
            acc_idx    <= d_acc_idx;
            alu_op     <= d_alu_op;
            mem_wr     <= d_mem_wr;
            jmp_en     <= d_jmp_en;
            branch_en  <= d_branch_en;
            illegal    <= d_illegal;
            imm        <= instr[IMM_W-1:0];
            mem_addr   <= instr[ADDR_W-1:0];
            jmp_addr   <= instr[ADDR_W-1:0];
            branch_off <= instr[BR_W-1:0];
        end else if (flush || out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Counters track ALU ops whose flags have not yet come back from execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (accept && is_alu && 32'(acc) == i) begin
                    if (!(flag_wb_valid && 32'(flag_wb_idx) == i))
                        pend[i] <= pend[i] + 1'b1;
                end else if (flag_wb_valid && 32'(flag_wb_idx) == i && pend[i] != '0) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expectations depend on DECODE_ILLEGAL_TRAP_EN.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [5:0]  flags;
    logic        flag_wb_valid;
    logic [0:0]  flag_wb_idx;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  acc_sel;
    logic [0:0]  acc_idx;
    logic [2:0]  alu_op;
    logic        mem_wr;
    logic        jmp_en;
    logic        branch_en;
    logic        illegal;
    logic [7:0]  imm;
    logic [9:0]  mem_addr;
    logic [9:0]  jmp_addr;
    logic [5:0]  branch_off;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .flags         (flags),
        .flag_wb_valid (flag_wb_valid),
        .flag_wb_idx   (flag_wb_idx),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .acc_sel       (acc_sel),
        .acc_idx       (acc_idx),
        .alu_op        (alu_op),
        .mem_wr        (mem_wr),
        .jmp_en        (jmp_en),
        .branch_en     (branch_en),
        .illegal       (illegal),
        .imm           (imm),
        .mem_addr      (mem_addr),
        .jmp_addr      (jmp_addr),
        .branch_off    (branch_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0; flags = '0;
        flag_wb_valid = 1'b0; flag_wb_idx = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", out_valid, 0);
        check("rst_sel", acc_sel, 0);
        check("rst_imm", imm, 0);
        reset = 1'b0;

        // LD imm acc0, op 000010
        in_valid = 1'b1; instr = 16'h0855;
        #1 check("ldi_rdy", in_ready, 1);
        tick();
        check("ldi_ov", out_valid, 1);
        check("ldi_sel", acc_sel, 4'b0001);
        check("ldi_imm", imm, 8'h55);
        check("ldi_idx", acc_idx, 0);
        check("ldi_boff", branch_off, 6'h15);
        check("ldi_addr", mem_addr, 10'h055);
        check("ldi_ill", illegal, 0);
        in_valid = 1'b0;
        tick();
        check("ldi_drain", out_valid, 0);

        // ADD acc1 then BNE acc1 interlock
        in_valid = 1'b1; instr = 16'h4400;
        tick();
        check("add_sel", acc_sel, 4'b1000);
        check("add_idx", acc_idx, 1);
        check("add_op", alu_op, 0);
        instr = 16'h9403; flags = 6'b010111;
        #1 check("bne_stall0", in_ready, 0);
        tick();
        check("bne_stall1", in_ready, 0);
        check("bne_bubble", out_valid, 0);
        flag_wb_valid = 1'b1; flag_wb_idx = 1'b1;
        #1 check("bne_wb_same", in_ready, 0);
        tick();
        flag_wb_valid = 1'b0;
        #1 check("bne_release", in_ready, 1);
        tick();
        check("bne_ov", out_valid, 1);
        check("bne_taken", branch_en, 1);
        check("bne_jmp", jmp_en, 0);
        check("bne_boff", branch_off, 6'h03);

        // BEQ acc1 with z=0: not taken
        instr = 16'h8C00;
        tick();
        check("beq_ov", out_valid, 1);
        check("beq_nt", branch_en, 0);

        // backpressure then back-to-back
        instr = 16'h08AA;
        tick();
        check("bp_imm0", imm, 8'hAA);
        out_ready = 1'b0; instr = 16'h82AB;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_ov", out_valid, 1);
            check("bp_imm", imm, 8'hAA);
            check("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 check("bp_go", in_ready, 1);
        tick();
        check("jmp_ov", out_valid, 1);
        check("jmp_en", jmp_en, 1);
        check("jmp_addr", jmp_addr, 10'h2AB);
        check("jmp_imm", imm, 8'hAB);

        // pend[0] saturation
        instr = 16'h4000;
        for (int k = 0; k < 3; k++) begin
            #1 check("sat_rdy", in_ready, 1);
            tick();
        end
        instr = 16'h6000;
        #1 check("sat_stall0", in_ready, 0);
        tick();
        check("sat_stall1", in_ready, 0);
        flag_wb_valid = 1'b1; flag_wb_idx = 1'b0;
        tick();
        flag_wb_valid = 1'b0;
        #1 check("sat_release", in_ready, 1);
        tick();
        check("and_op", alu_op, 3'd4);
        check("and_sel", acc_sel, 4'b0010);

        // flush with downstream stalled
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("fl_hold", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        #1 check("fl_rdy", in_ready, 0);
        tick();
        flush = 1'b0;
        check("fl_ov", out_valid, 0);
        in_valid = 1'b1; instr = 16'h4000;
        #1 check("fl_pend_kept", in_ready, 0);

        // async reset mid-stall
        #2 reset = 1'b1;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_sel", acc_sel, 0);
        check("ar_op", alu_op, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // illegal opcode 111111
        in_valid = 1'b1; instr = 16'hFC0F;
        tick();
        check("ill_ov", out_valid, 1);
        check("ill_sel", acc_sel, 0);
        check("ill_jmp", jmp_en, 0);
        check("ill_wr", mem_wr, 0);
        check("ill_imm", imm, 8'h0F);
        instr = 16'h0455;
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ill_flag", illegal, 1);
        #1 check("trap_rdy0", in_ready, 0);
        tick();
        check("trap_rdy1", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 check("trap_exit", in_ready, 1);
`else
        check("ill_flag", illegal, 0);
        #1 check("ill_next", in_ready, 1);
`endif
        tick();
        check("ldm_ov", out_valid, 1);
        check("ldm_sel", acc_sel, 4'b1100);
        check("ldm_ill", illegal, 0);

        // ST acc1
        instr = 16'h1400;
        tick();
        check("st_wr", mem_wr, 1);
        check("st_sel", acc_sel, 0);
        check("st_idx", acc_idx, 1);
        in_valid = 1'b0;
        tick();
        check("end_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
